// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: four byte reads per word, delivers (pc, is) to decode
module if_fetch #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy_in,
  input  logic            mem_busy,
  output logic            mem_rd,
  output logic [XLEN-1:0] mem_a,
  input  logic [7:0]      mem_din,
  input  logic            stall,
  input  logic            jmp,
  input  logic [XLEN-1:0] jmp_pc,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_is,
  output logic            if_vld
);

  typedef enum logic [2:0] {S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
                            WAIT = 3'd4, HOLD = 3'd5} state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] fpc;
  logic            pend;
  logic [1:0]      tag;
  logic [XLEN-1:0] byte_buf;
  logic [XLEN-1:0] hold_word;

  logic            issue, redirect, out_free;
  logic            deliver, to_hold;
  logic [XLEN-1:0] word, deliver_word;

  // A frozen capture of byte 3 leaves pend clear in WAIT, so the buffer then holds the whole word.
  assign word = pend ? {mem_din, byte_buf[23:0]} : byte_buf;

  always_ff @(posedge clk) begin
    if (rst) state <= S0;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (rdy_in && jmp) begin
      state_nx = S0;
    end else if (rdy_in) begin
      case (state)
        S0:      if (issue) state_nx = S1;
        S1:      if (issue) state_nx = S2;
        S2:      if (issue) state_nx = S3;
        S3:      if (issue) state_nx = WAIT;
        WAIT:    state_nx = out_free ? S0 : HOLD;
        HOLD:    if (out_free) state_nx = S0;
        default: state_nx = S0;
      endcase
    end
  end

  always_comb begin
    redirect     = rdy_in && jmp;
    out_free     = !if_vld || !stall;
    issue        = rdy_in && !mem_busy && !jmp && !rst && (state[2] == 1'b0);
    mem_rd       = issue;
    mem_a        = fpc + {{(XLEN-2){1'b0}}, state[1:0]};
    deliver      = rdy_in && !jmp && out_free && (state == WAIT || state == HOLD);
    to_hold      = rdy_in && !jmp && !out_free && (state == WAIT);
    deliver_word = (state == HOLD) ? hold_word : word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc       <= RESET_PC;
      pend      <= 1'b0;
      tag       <= 2'd0;
      byte_buf  <= '0;
      hold_word <= '0;
      if_pc     <= '0;
      if_is     <= '0;
      if_vld    <= 1'b0;
    end else begin
      // Returned data is captured even while frozen; a redirect drops it.
      if (pend && !redirect) byte_buf[{tag, 3'b000} +: 8] <= mem_din;

      if (redirect) begin
        pend <= 1'b0;
      end else if (issue) begin
        pend <= 1'b1;
        tag  <= state[1:0];
      end else begin
        pend <= 1'b0;
      end

      if (rdy_in) begin
        if (redirect) begin
          fpc    <= jmp_pc;
          if_vld <= 1'b0;
          if_is  <= '0;
        end else begin
          if (to_hold) hold_word <= word;
          if (deliver) begin
            if_is  <= deliver_word;
            if_pc  <= fpc + 32'd4;
            if_vld <= 1'b1;
            fpc    <= fpc + 32'd4;
          end else if (if_vld && !stall) begin
            if_vld <= 1'b0;
            if_is  <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed self-checking bench for if_fetch
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst, rdy_in, mem_busy, stall, jmp;
  logic [31:0] jmp_pc;
  logic [7:0]  mem_din;
  logic        mem_rd, if_vld;
  logic [31:0] mem_a, if_pc, if_is;

  if_fetch #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in), .mem_busy(mem_busy),
    .mem_rd(mem_rd), .mem_a(mem_a), .mem_din(mem_din),
    .stall(stall), .jmp(jmp), .jmp_pc(jmp_pc),
    .if_pc(if_pc), .if_is(if_is), .if_vld(if_vld)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] jpc;
    logic [31:0] e_pc;
    logic [31:0] e_is;
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory answers a granted request with its byte the following cycle.
  task automatic cyc();
    logic        r;
    logic [31:0] a;
    @(negedge clk);
    r = mem_rd;
    a = mem_a;
    @(posedge clk);
    #1;
    mem_din = r ? mem[a[7:0]] : 8'hEE;
  endtask

  task automatic wait_vld(input string nm);
    int n = 0;
    while (!if_vld && n < 12) begin
      cyc();
      n++;
    end
    chk({nm, " vld"}, 32'(if_vld), 32'd1);
  endtask

  task automatic do_jmp(input logic [31:0] a);
    jmp = 1'b1;
    jmp_pc = a;
    #1;
    chk("jmp cycle mem_rd", 32'(mem_rd), 32'd0);
    cyc();
    jmp = 1'b0;
    #1;
    chk("jmp flush vld", 32'(if_vld), 32'd0);
    chk("jmp flush is", if_is, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rdy_in = 1'b1; mem_busy = 1'b0; stall = 1'b0;
    jmp = 1'b0; jmp_pc = 32'h0; mem_din = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[0] = 8'h93; mem[1] = 8'h00; mem[2] = 8'h10; mem[3] = 8'h00;
    vt[0] = '{32'h0000_0040, 32'h0000_0044, 32'h4342_4140};
    vt[1] = '{32'h0000_0100, 32'h0000_0104, 32'h0010_0093};
    vt[2] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFE_FDFC};
    vt[3] = '{32'h0000_0081, 32'h0000_0085, 32'h8483_8281};
    vt[4] = '{32'h0000_01FE, 32'h0000_0202, 32'h0093_FFFE};

    // reset state
    cyc(); cyc(); #1;
    chk("reset vld", 32'(if_vld), 32'd0);
    chk("reset is", if_is, 32'd0);
    chk("reset pc", if_pc, 32'd0);
    chk("reset mem_rd", 32'(mem_rd), 32'd0);
    rst = 1'b0; #1;

    // first word: four consecutive byte reads, delivered on the 5th cycle
    for (int k = 0; k < 4; k++) begin
      chk("t1 mem_rd", 32'(mem_rd), 32'd1);
      chk("t1 mem_a", mem_a, 32'(k));
      cyc(); #1;
    end
    chk("t1 wait mem_rd", 32'(mem_rd), 32'd0);
    cyc(); #1;
    chk("t1 vld", 32'(if_vld), 32'd1);
    chk("t1 is", if_is, 32'h0010_0093);
    chk("t1 pc", if_pc, 32'd4);
    chk("t1 next mem_a", mem_a, 32'd4);

    // consumption then word at 4
    cyc(); #1;
    chk("t1 consumed vld", 32'(if_vld), 32'd0);
    chk("t1 consumed is", if_is, 32'd0);
    wait_vld("t2 word4");
    chk("t2 word4 is", if_is, 32'h0706_0504);
    chk("t2 word4 pc", if_pc, 32'd8);

    // mem_busy for two cycles in S2 of fpc=8
    cyc(); cyc();
    mem_busy = 1'b1; #1;
    chk("t2 busy1 mem_rd", 32'(mem_rd), 32'd0);
    cyc(); #1;
    chk("t2 busy2 mem_rd", 32'(mem_rd), 32'd0);
    cyc();
    mem_busy = 1'b0; #1;
    chk("t2 retry mem_rd", 32'(mem_rd), 32'd1);
    chk("t2 retry mem_a", mem_a, 32'd10);
    cyc(); cyc(); #1;
    chk("t2 wait mem_rd", 32'(mem_rd), 32'd0);
    cyc(); #1;
    chk("t2 vld", 32'(if_vld), 32'd1);
    chk("t2 is", if_is, 32'h0B0A_0908);
    chk("t2 pc", if_pc, 32'd12);

    // stall after delivery; next word parks in HOLD
    do_jmp(32'h0);
    for (int i = 0; i < 5; i++) cyc();
    #1;
    chk("t3 vld", 32'(if_vld), 32'd1);
    chk("t3 pc", if_pc, 32'd4);
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(); #1;
      chk("t3 stall pc", if_pc, 32'd4);
      chk("t3 stall vld", 32'(if_vld), 32'd1);
      chk("t3 stall is", if_is, 32'h0010_0093);
    end
    chk("t3 hold mem_rd", 32'(mem_rd), 32'd0);
    stall = 1'b0;
    cyc(); #1;
    chk("t3 release vld", 32'(if_vld), 32'd1);
    chk("t3 release pc", if_pc, 32'd8);
    chk("t3 release is", if_is, 32'h0706_0504);
    chk("t3 release mem_rd", 32'(mem_rd), 32'd1);
    chk("t3 release mem_a", mem_a, 32'd8);

    // redirect while stalled with HOLD occupied
    stall = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    #1;
    chk("t5 hold mem_rd", 32'(mem_rd), 32'd0);
    chk("t5 held pc", if_pc, 32'd8);
    do_jmp(32'h40);
    stall = 1'b0;
    wait_vld("t5");
    chk("t5 pc", if_pc, 32'h44);
    chk("t5 is", if_is, 32'h4342_4140);

    // redirect in S2 of fpc=0x20
    do_jmp(32'h20);
    cyc(); cyc(); #1;
    do_jmp(32'h100);
    chk("t4 mem_rd", 32'(mem_rd), 32'd1);
    chk("t4 mem_a", mem_a, 32'h100);
    wait_vld("t4");
    chk("t4 pc", if_pc, 32'h104);
    chk("t4 is", if_is, 32'h0010_0093);

    // freeze mid-word; in-flight byte still captured
    do_jmp(32'h80);
    cyc(); cyc(); #1;
    rdy_in = 1'b0; #1;
    chk("t7 frozen mem_rd", 32'(mem_rd), 32'd0);
    cyc(); cyc(); cyc();
    rdy_in = 1'b1; #1;
    chk("t7 resume mem_rd", 32'(mem_rd), 32'd1);
    chk("t7 resume mem_a", mem_a, 32'h82);
    wait_vld("t7");
    chk("t7 is", if_is, 32'h8382_8180);
    chk("t7 pc", if_pc, 32'h84);

    // reset mid-fetch in S3
    do_jmp(32'h40);
    cyc(); cyc(); cyc(); #1;
    rst = 1'b1; #1;
    chk("t6 rst mem_rd", 32'(mem_rd), 32'd0);
    cyc();
    rst = 1'b0; #1;
    chk("t6 vld", 32'(if_vld), 32'd0);
    chk("t6 is", if_is, 32'd0);
    chk("t6 pc", if_pc, 32'd0);
    chk("t6 mem_rd", 32'(mem_rd), 32'd1);
    chk("t6 mem_a", mem_a, 32'd0);
    wait_vld("t6");
    chk("t6 word is", if_is, 32'h0010_0093);
    chk("t6 word pc", if_pc, 32'd4);

    // redirect targets, including unaligned and wrapping addresses
    for (int i = 0; i < 5; i++) begin
      do_jmp(vt[i].jpc);
      wait_vld("vec");
      chk("vec pc", if_pc, vt[i].e_pc);
      chk("vec is", if_is, vt[i].e_is);
      chk("vec next mem_a", mem_a, vt[i].e_pc);
      chk("vec next mem_rd", 32'(mem_rd), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
